// File: rtl/regmon_pkg.sv
// rtl/regmon_pkg.sv - shared widths, slice helper and scan-mode enum for the register monitor
package regmon_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } scan_state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int id_w_f(input int num_regs);
    return clog2_f(num_regs);
  endfunction

  // A single-slice display still needs a one-bit select port.
  function automatic int sl_w_f(input int nslice);
    return (nslice <= 2) ? 1 : clog2_f(nslice);
  endfunction

  function automatic int slice_offset(input int sel, input int disp_w);
    return sel * disp_w;
  endfunction

endpackage

// File: rtl/regmon_scan_timer.sv
// rtl/regmon_scan_timer.sv - dwell counter and wrapping 1..NUM_REGS-1 scan index
module regmon_scan_timer
  import regmon_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int SCAN_DWELL = 50_000_000,
  localparam int ID_W      = id_w_f(NUM_REGS),
  localparam int CNT_W     = clog2_f(SCAN_DWELL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic [ID_W-1:0] index
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DWELL - 1);
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REGS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_index;

  // The index is held while disabled so re-entering scan resumes where it left off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_index <= ID_W'(1);
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt   <= '0;
      r_index <= (r_index == LAST_IDX) ? ID_W'(1) : r_index + ID_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign index = r_index;

endmodule

// File: rtl/regfile_monitor.sv
// rtl/regfile_monitor.sv - shadows register-file writebacks and drives a registered display slice
module regfile_monitor
  import regmon_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int DISP_W     = 16,
  parameter int SCAN_DWELL = 50_000_000,
  localparam int ID_W      = id_w_f(NUM_REGS),
  localparam int NSLICE    = DATA_W / DISP_W,
  localparam int SL_W      = sl_w_f(NSLICE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ID_W-1:0]   write_id,
  input  logic [DATA_W-1:0] write_data,
  input  logic              freeze,
  input  logic              auto_scan,
  input  logic [ID_W-1:0]   sel_address,
  input  logic [SL_W-1:0]   slice_sel,
  input  logic              dirty_clear,
  output logic [DISP_W-1:0] disp_out,
  output logic [ID_W-1:0]   disp_id,
  output logic              disp_dirty,
  output logic              missed
);

  localparam int OFF_W = (clog2_f(DATA_W) < 1) ? 1 : clog2_f(DATA_W);

  scan_state_e       w_mode;
  logic [ID_W-1:0]   w_scan_idx;
  logic [ID_W-1:0]   w_sel;
  logic              w_capture;
  logic              w_slice_ok;
  logic [SL_W-1:0]   w_slice;
  logic [OFF_W-1:0]  w_off;

  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [DISP_W-1:0] r_disp_out;
  logic [ID_W-1:0]   r_disp_id;
  logic              r_disp_dirty;
  logic              r_missed;

  assign w_mode     = auto_scan ? SCAN : MANUAL;
  assign w_sel      = (w_mode == SCAN) ? w_scan_idx : sel_address;
  assign w_capture  = write_enable && !freeze && (write_id != '0);
  assign w_slice_ok = (32'(slice_sel) < NSLICE);
  assign w_slice    = w_slice_ok ? slice_sel : '0;
  assign w_off      = OFF_W'(slice_offset(int'(w_slice), DISP_W));

  regmon_scan_timer #(
    .NUM_REGS   (NUM_REGS),
    .SCAN_DWELL (SCAN_DWELL)
  ) u_scan_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (w_mode == SCAN),
    .index  (w_scan_idx)
  );

  // Outputs sample pre-edge shadow state, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      r_dirty      <= '0;
      r_missed     <= 1'b0;
      r_disp_out   <= '0;
      r_disp_id    <= '0;
      r_disp_dirty <= 1'b0;
    end else begin
      if (w_capture) r_shadow[write_id] <= write_data;
      // The capture assignment comes last so set wins over a same-cycle clear.
      if (!freeze) begin
        if (dirty_clear) r_dirty[w_sel] <= 1'b0;
        if (w_capture) r_dirty[write_id] <= 1'b1;
      end
      if (freeze && write_enable && (write_id != '0)) r_missed <= 1'b1;
      r_disp_id    <= w_sel;
      r_disp_dirty <= r_dirty[w_sel];
      if ((w_sel == '0) || !w_slice_ok) r_disp_out <= '0;
      else r_disp_out <= r_shadow[w_sel][w_off +: DISP_W];
    end
  end

  assign disp_out   = r_disp_out;
  assign disp_id    = r_disp_id;
  assign disp_dirty = r_disp_dirty;
  assign missed     = r_missed;

endmodule

// File: tb/tb_regfile_monitor.sv
// tb/tb_regfile_monitor.sv - vector table, scan/reset sequences and randomized model check for regfile_monitor
module tb_regfile_monitor;

  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 8;
  localparam int DISP_W     = 16;
  localparam int SCAN_DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  write_id = '0;
  logic [31:0] write_data = '0;
  logic        freeze = 1'b0;
  logic        auto_scan = 1'b0;
  logic [2:0]  sel_address = '0;
  logic        slice_sel = 1'b0;
  logic        dirty_clear = 1'b0;
  logic [15:0] disp_out;
  logic [2:0]  disp_id;
  logic        disp_dirty;
  logic        missed;

  int total = 0;
  int bad   = 0;

  regfile_monitor #(
    .DATA_W     (DATA_W),
    .NUM_REGS   (NUM_REGS),
    .DISP_W     (DISP_W),
    .SCAN_DWELL (SCAN_DWELL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .write_id     (write_id),
    .write_data   (write_data),
    .freeze       (freeze),
    .auto_scan    (auto_scan),
    .sel_address  (sel_address),
    .slice_sel    (slice_sel),
    .dirty_clear  (dirty_clear),
    .disp_out     (disp_out),
    .disp_id      (disp_id),
    .disp_dirty   (disp_dirty),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  id;
    logic [31:0] data;
    logic        frz;
    logic [2:0]  sel;
    logic        sl;
    logic        clr;
    logic [15:0] e_out;
    logic [2:0]  e_id;
    logic        e_dirty;
    logic        e_missed;
  } vec_t;

  vec_t vecs [13];

  logic [31:0] m_sh [NUM_REGS];
  bit          m_dirty [NUM_REGS];
  bit          m_missed;
  int          m_cnt;
  int          m_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] id, input logic [31:0] data,
                       input logic frz, input logic aut, input logic [2:0] sel,
                       input logic sl, input logic clr);
    write_enable = we;
    write_id     = id;
    write_data   = data;
    freeze       = frz;
    auto_scan    = aut;
    sel_address  = sel;
    slice_sel    = sl;
    dirty_clear  = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_sh[i]    = '0;
      m_dirty[i] = 1'b0;
    end
    m_missed = 1'b0;
    m_cnt    = 0;
    m_idx    = 1;
  endtask

  // Predicts outputs after the coming edge from the current inputs, then advances the model.
  task automatic model_step(output logic [15:0] e_out, output logic [2:0] e_id,
                            output logic e_dirty, output logic e_missed);
    int shown;
    shown   = auto_scan ? m_idx : int'(sel_address);
    e_id    = 3'(shown);
    e_out   = (shown == 0) ? 16'h0 : 16'((m_sh[shown] >> (DISP_W * int'(slice_sel))) & 32'hFFFF);
    e_dirty = m_dirty[shown];
    if (!freeze) begin
      if (dirty_clear) m_dirty[shown] = 1'b0;
      if (write_enable && write_id != 0) begin
        m_sh[write_id]    = write_data;
        m_dirty[write_id] = 1'b1;
      end
    end else if (write_enable && write_id != 0) begin
      m_missed = 1'b1;
    end
    e_missed = m_missed;
    if (auto_scan) begin
      if (m_cnt == SCAN_DWELL - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == NUM_REGS - 1) ? 1 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e_out;
    logic [2:0]  e_id;
    logic        e_dirty;
    logic        e_missed;
    logic        aut;

    //           we    id    data          frz   sel   sl    clr   out       id    dty   mis
    vecs[0]  = '{1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd5, 1'b1, 1'b0, 16'h0000, 3'd5, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd5, 1'b1, 1'b0, 16'hDEAD, 3'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd5, 1'b0, 1'b0, 16'hBEEF, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd3, 32'h00001234, 1'b1, 3'd3, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd3, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3'd3, 32'h00001234, 1'b0, 3'd3, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd3, 1'b0, 1'b0, 16'h1234, 3'd3, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 3'd7, 32'h0000000A, 1'b0, 3'd7, 1'b0, 1'b1, 16'h0000, 3'd7, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd7, 1'b0, 1'b0, 16'h000A, 3'd7, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd7, 1'b0, 1'b1, 16'h000A, 3'd7, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd7, 1'b0, 1'b0, 16'h000A, 3'd7, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(disp_out), 32'h0);
    check("rst_id", 32'(disp_id), 32'h0);
    check("rst_dirty", 32'(disp_dirty), 32'h0);
    check("rst_missed", 32'(missed), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].id, vecs[i].data, vecs[i].frz, 1'b0, vecs[i].sel, vecs[i].sl, vecs[i].clr);
      tick();
      check($sformatf("vec%0d_out", i), 32'(disp_out), 32'(vecs[i].e_out));
      check($sformatf("vec%0d_id", i), 32'(disp_id), 32'(vecs[i].e_id));
      check($sformatf("vec%0d_dirty", i), 32'(disp_dirty), 32'(vecs[i].e_dirty));
      check($sformatf("vec%0d_missed", i), 32'(missed), 32'(vecs[i].e_missed));
    end

    // Auto-scan from a fresh index of 1: each register shown for SCAN_DWELL cycles, 0 never shown
    drive(1'b1, 3'd2, 32'h55, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < 34; n++) begin
      drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      tick();
      check($sformatf("scan%0d_id", n), 32'(disp_id), 32'(1 + (n / SCAN_DWELL) % (NUM_REGS - 1)));
      if (disp_id == 3'd2) begin
        check($sformatf("scan%0d_x2", n), 32'(disp_out), 32'h55);
        check($sformatf("scan%0d_x2dirty", n), 32'(disp_dirty), 32'h1);
      end
    end

    // Asynchronous reset in the middle of a dwell period
    #3;
    rst = 1'b0;
    #1;
    check("arst_out", 32'(disp_out), 32'h0);
    check("arst_id", 32'(disp_id), 32'h0);
    check("arst_dirty", 32'(disp_dirty), 32'h0);
    check("arst_missed", 32'(missed), 32'h0);
    tick();
    rst = 1'b1;
    check("arst_release_id", 32'(disp_id), 32'h0);
    for (int n = 0; n < 2 * SCAN_DWELL; n++) begin
      tick();
      check($sformatf("rescan%0d_id", n), 32'(disp_id), (n < SCAN_DWELL) ? 32'd1 : 32'd2);
      if (n >= SCAN_DWELL) check($sformatf("rescan%0d_x2", n), 32'(disp_out), 32'h0);
    end

    // Randomized traffic against the reference model
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    aut = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) aut = ~aut;
      drive(($urandom_range(0, 1) == 1), 3'($urandom_range(0, NUM_REGS - 1)), $urandom(),
            ($urandom_range(0, 7) == 0), aut, 3'($urandom_range(0, NUM_REGS - 1)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      model_step(e_out, e_id, e_dirty, e_missed);
      tick();
      check($sformatf("rnd%0d_out", n), 32'(disp_out), 32'(e_out));
      check($sformatf("rnd%0d_id", n), 32'(disp_id), 32'(e_id));
      check($sformatf("rnd%0d_dirty", n), 32'(disp_dirty), 32'(e_dirty));
      check($sformatf("rnd%0d_missed", n), 32'(missed), 32'(e_missed));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_monitor.md
Name: regfile_monitor

Overview:
- Parametrised successor of the LED register-capture debug block.
- Snoops the core's register-file writeback port and keeps a shadow copy of x1..x(NUM_REGS-1).
- Drives a DISP_W-bit board display with one selected slice of one shadow register.
- Adds auto-scan mode, freeze/snapshot, per-register dirty flags and a registered output.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, architectural registers; index 0 is hard-wired zero; power of two, range 2..32.
- DISP_W, 16, display width; DATA_W must be a multiple of DISP_W.
- SCAN_DWELL, 50_000_000, clock cycles each register is shown in auto-scan; must be >= 2.
- Derived: ID_W = clog2(NUM_REGS); NSLICE = DATA_W/DISP_W; SL_W = max(1, clog2(NSLICE)).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- write_enable  in  1  writeback strobe
- write_id  in  ID_W  destination register
- write_data  in  DATA_W  writeback data
- freeze  in  1  1 = ignore writebacks (hold snapshot)
- auto_scan  in  1  1 = auto-scan mode, 0 = manual select
- sel_address  in  ID_W  manual register select
- slice_sel  in  SL_W  DISP_W slice; 0 = least significant
- dirty_clear  in  1  one-cycle pulse; clears the dirty flag of the displayed register
- disp_out  out  DISP_W  displayed slice
- disp_id  out  ID_W  index currently displayed
- disp_dirty  out  1  dirty flag of the displayed register
- missed  out  1  sticky; a write arrived while frozen

Behaviour:
- Reset (rst low, async): all shadow registers 0, dirty flags 0, scan index 1, dwell counter 0, disp_out 0, disp_id 0, disp_dirty 0, missed 0.
- Capture: on a clk edge with write_enable=1, freeze=0 and write_id != 0: shadow[write_id] <= write_data and dirty[write_id] <= 1. Writes to x0 are dropped and set no flag.
- Freeze: while freeze=1 no shadow register or dirty flag changes. A write with write_enable=1 and write_id != 0 sets missed=1. missed clears only on reset.
- Selection index: sel_address when auto_scan=0; otherwise scan index.
- Scan timer: counts 0..SCAN_DWELL-1 only while auto_scan=1. At the terminal count the scan index advances 1→2→…→NUM_REGS-1→1 (never 0) and the counter returns to 0.
- Leaving auto-scan resets the counter to 0 and holds the scan index. Re-entering resumes from the held index.
- Output: disp_out = slice slice_sel of the shadow at the selection index; index 0 or slice_sel >= NSLICE gives 0.
- disp_id and disp_dirty follow the same selection index.
- All three outputs are registered: exactly 1 cycle latency from any input change.
- Write-through: a capture and a display of the same register in one cycle outputs the OLD value in the next cycle and the NEW value one cycle later. There is no bypass.
- dirty_clear clears dirty[selection index] in that cycle. A capture and a clear of the same register in the same cycle leave the flag SET.
- Reset mid-scan or mid-write aborts immediately; there is no partial update.

Decomposition:
- Package regmon_pkg holds: the ID_W/SL_W derivation functions, the DISP_W slice-extract function, and the enum for scan state (MANUAL, SCAN).
- Sub-module regmon_scan_timer: dwell counter plus wrapping scan index, with ports clk, rst, enable, index. Everything else lives in the top.

Test Plan:
- Reset, then write x5=0xDEADBEEF; manual sel=5, slice 1 → disp_out=0xDEAD, disp_id=5, disp_dirty=1 one cycle later; slice 0 → 0xBEEF.
- Write x0=0xFFFFFFFF; sel=0 → disp_out=0, no dirty flag set.
- freeze=1, write x3=0x1234 → shadow x3 unchanged (0), missed=1. freeze=0, write x3=0x1234 → disp_out=0x1234; missed stays 1.
- SCAN_DWELL=4, NUM_REGS=4, auto_scan=1 → disp_id sequence 1,2,3,1 with each value held 4 cycles; never 0.
- Same-cycle write x7=0xA and dirty_clear with sel=7 → disp_dirty stays 1. Clear alone next cycle → disp_dirty=0 in the following cycle.
- Assert rst low mid-scan with x2=0x55 → outputs 0 asynchronously; after release disp_id=0, scan restarts at index 1.
